// File: rtl/conv_window_ctrl_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | conv_window_ctrl_if                                                     |
// | Line-memory read, window-register control and PE patch handshake.      |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
interface conv_window_ctrl_if #(
    parameter int DIM_W = 8
);
    logic             rd_en;
    logic [DIM_W-1:0] rd_row;
    logic [DIM_W-1:0] rd_col;
    logic             load_en;
    logic             clear;
    logic             win_valid;
    logic             win_ready;
    logic [DIM_W-1:0] win_row;
    logic [DIM_W-1:0] win_col;

    modport master (
        output rd_en, rd_row, rd_col, load_en, clear, win_valid, win_row, win_col,
        input  win_ready
    );

    modport slave (
        input  rd_en, rd_row, rd_col, load_en, clear, win_valid, win_row, win_col,
        output win_ready
    );
endinterface
`default_nettype wire

// File: rtl/conv_window_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | conv_window_ctrl                                                        |
// | Sliding-window sequencer: walks a feature map in row bands, drives the  |
// | line-memory reads / window shift-loads and presents patches to the PE. |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module conv_window_ctrl #(
    parameter int K_H   = 3,
    parameter int K_W   = 3,
    parameter int DIM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIM_W-1:0] cfg_h,
    input  logic [DIM_W-1:0] cfg_w,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    conv_window_ctrl_if.master win_if
);
    localparam logic [DIM_W-1:0] c_k_h    = DIM_W'(K_H);
    localparam logic [DIM_W-1:0] c_k_w    = DIM_W'(K_W);
    localparam logic [DIM_W-1:0] c_k_w_m1 = DIM_W'(K_W - 1);
    localparam logic [DIM_W-1:0] c_one    = DIM_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_READ  = 3'd2,
        S_LOAD  = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [DIM_W-1:0] r_band, w_band_nxt;
    logic [DIM_W-1:0] r_col, w_col_nxt;
    logic [DIM_W-1:0] r_cfg_h, r_cfg_w;
    logic             r_err, w_err_nxt;
    logic             w_cfg_ld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_band  <= '0;
            r_col   <= '0;
            r_cfg_h <= '0;
            r_cfg_w <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_band  <= w_band_nxt;
            r_col   <= w_col_nxt;
            r_err   <= w_err_nxt;
            if (w_cfg_ld) begin
                r_cfg_h <= cfg_h;
                r_cfg_w <= cfg_w;
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_band_nxt       = r_band;
        w_col_nxt        = r_col;
        w_err_nxt        = 1'b0;
        w_cfg_ld         = 1'b0;
        win_if.rd_en     = 1'b0;
        win_if.rd_row    = '0;
        win_if.rd_col    = '0;
        win_if.load_en   = 1'b0;
        win_if.clear     = 1'b0;
        win_if.win_valid = 1'b0;
        win_if.win_row   = '0;
        win_if.win_col   = '0;
        done             = 1'b0;
        busy             = (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    if ((cfg_h < c_k_h) || (cfg_w < c_k_w)) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_cfg_ld    = 1'b1;
                        w_band_nxt  = '0;
                        w_state_nxt = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                win_if.clear = 1'b1;
                w_col_nxt    = '0;
                w_state_nxt  = S_READ;
            end
            S_READ: begin
                win_if.rd_en  = 1'b1;
                win_if.rd_row = r_band;
                win_if.rd_col = r_col;
                w_state_nxt   = S_LOAD;
            end
            S_LOAD: begin
                win_if.load_en = 1'b1;
                if (r_col >= c_k_w_m1) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_col_nxt   = r_col + c_one;
                    w_state_nxt = S_READ;
                end
            end
            S_WAIT: begin
                win_if.win_valid = 1'b1;
                win_if.win_row   = r_band;
                win_if.win_col   = r_col - c_k_w_m1;
                if (win_if.win_ready) begin
                    if (r_col < (r_cfg_w - c_one)) begin
                        w_col_nxt   = r_col + c_one;
                        w_state_nxt = S_READ;
                    end else if (r_band < (r_cfg_h - c_k_h)) begin
                        w_band_nxt  = r_band + c_one;
                        w_state_nxt = S_CLEAR;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Abort overrides everything: wipe the window and suppress any transfer.
        if (abort && (r_state != S_IDLE)) begin
            w_state_nxt      = S_IDLE;
            w_band_nxt       = r_band;
            w_col_nxt        = r_col;
            win_if.clear     = 1'b1;
            win_if.rd_en     = 1'b0;
            win_if.load_en   = 1'b0;
            win_if.win_valid = 1'b0;
        end
    end

    assign err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_conv_window_ctrl                                                     |
// | Randomized self-checking bench against a patch-list / timing model.    |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tb_conv_window_ctrl;
    localparam int K_H   = 3;
    localparam int K_W   = 3;
    localparam int DIM_W = 8;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [DIM_W-1:0] cfg_h = '0;
    logic [DIM_W-1:0] cfg_w = '0;
    logic             busy, done, err;

    int n_checks = 0;
    int n_errors = 0;

    conv_window_ctrl_if #(.DIM_W(DIM_W)) win_if ();

    conv_window_ctrl #(.K_H(K_H), .K_W(K_W), .DIM_W(DIM_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cfg_h  (cfg_h),
        .cfg_w  (cfg_w),
        .abort  (abort),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .win_if (win_if.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {busy, done, err, win_if.rd_en, win_if.load_en, win_if.clear, win_if.win_valid,
                win_if.rd_row, win_if.rd_col, win_if.win_row, win_if.win_col};
    endfunction

    // mode 0: ready always high; 1: random ready; 2: 4-cycle stall on the 2nd patch
    task automatic run_pass(input int h, input int w, input int mode);
        logic [15:0]      q[$];
        logic [15:0]      exp_patch;
        logic [DIM_W-1:0] prev_r, prev_c;
        int bands, per, stalls, clears, reads, clr_cyc, acc_idx, stall_left;
        bit prev_stall, prev_rd, first_pending, done_seen, rdy, v;
        bands = h - K_H + 1;
        per   = 1 + 2 * w + (w - K_W + 1);
        for (int r = 0; r < bands; r++)
            for (int c = 0; c <= w - K_W; c++)
                q.push_back({8'(r), 8'(c)});
        stalls = 0; clears = 0; reads = 0; clr_cyc = 0; acc_idx = 0; stall_left = 4;
        prev_stall = 0; prev_rd = 0; first_pending = 0; done_seen = 0;
        prev_r = '0; prev_c = '0;
        for (int cyc = 0; cyc < 4000 && !done_seen; cyc++) begin
            @(negedge clk);
            v = win_if.win_valid;
            if (cyc == 0) begin
                chk("idle_busy", busy, 0);
                start = 1'b1;
                cfg_h = DIM_W'(h);
                cfg_w = DIM_W'(w);
            end else begin
                start = 1'($urandom_range(0, 1));
                cfg_h = DIM_W'($urandom);
                cfg_w = DIM_W'($urandom);
                chk("busy", busy, 1);
                if (win_if.clear) begin
                    chk("clear_cyc", cyc, 1 + clears * per + stalls);
                    clr_cyc = cyc; clears++; reads = 0; first_pending = 1;
                end
                if (win_if.rd_en) begin
                    chk("rd_row", win_if.rd_row, clears - 1);
                    chk("rd_col", win_if.rd_col, reads);
                    reads++;
                end
                if (win_if.load_en) chk("rd_latency", prev_rd, 1);
                if (prev_stall)
                    chk("stall_hold",
                        {v, win_if.rd_en, win_if.load_en, win_if.win_row, win_if.win_col},
                        {1'b1, 1'b0, 1'b0, prev_r, prev_c});
            end
            case (mode)
                0:       rdy = 1;
                1:       rdy = ($urandom_range(0, 3) != 0);
                default: rdy = !(v && acc_idx == 1 && stall_left > 0);
            endcase
            if (mode == 2 && v && !rdy) stall_left--;
            if (v) begin
                if (first_pending) begin
                    chk("first_valid", cyc, clr_cyc + 2 * K_W + 1);
                    first_pending = 0;
                end
                if (rdy) begin
                    if (q.size() == 0) chk("extra_patch", 1, 0);
                    else begin
                        exp_patch = q.pop_front();
                        chk("patch", {win_if.win_row, win_if.win_col}, exp_patch);
                        acc_idx++;
                    end
                end else stalls++;
            end
            prev_stall = v && !rdy;
            prev_r     = win_if.win_row;
            prev_c     = win_if.win_col;
            prev_rd    = win_if.rd_en;
            win_if.win_ready = rdy;
            if (done) begin
                chk("done_cyc", cyc, 1 + bands * per + stalls);
                chk("patches_left", q.size(), 0);
                chk("err_in_pass", err, 0);
                start = 1'b0;
                win_if.win_ready = 1'b0;
                done_seen = 1;
            end
        end
        if (!done_seen) chk("pass_timeout", 0, 1);
        @(negedge clk);
        start = 1'b0;
        chk("post_idle", {busy, done}, 0);
    endtask

    task automatic bad_start(input int h, input int w, input bit with_abort);
        @(negedge clk);
        start = 1'b1; abort = with_abort; cfg_h = DIM_W'(h); cfg_w = DIM_W'(w);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk(with_abort ? "abort_start_c1" : "err_c1", {err, busy, win_if.rd_en},
            {!with_abort, 2'b00});
        @(negedge clk);
        chk("err_c2", {err, busy, win_if.rd_en}, 0);
    endtask

    initial begin
        win_if.win_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outs", all_outs(), 0);
        rst_n = 1'b1;

        run_pass(5, 5, 0);
        run_pass(3, 3, 0);
        run_pass(5, 5, 2);
        run_pass(3, 7, 1);
        run_pass(7, 3, 1);

        bad_start(2, 5, 0);
        bad_start(5, 2, 0);
        bad_start(5, 5, 1);

        // abort in the READ cycle of the second band
        @(negedge clk);
        start = 1'b1; cfg_h = 8'd5; cfg_w = 8'd5; win_if.win_ready = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        abort = 1'b1;
        #1;
        chk("abort_outs", {win_if.clear, win_if.load_en, win_if.rd_en, win_if.win_valid, busy},
            5'b10001);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", {busy, done, err}, 0);
        begin
            bit any_done = 0;
            repeat (10) begin
                @(negedge clk);
                any_done |= done;
            end
            chk("abort_no_done", any_done, 0);
        end
        win_if.win_ready = 1'b0;
        run_pass(5, 5, 1);

        // asynchronous reset in the middle of a pass
        @(negedge clk);
        start = 1'b1; cfg_h = 8'd5; cfg_w = 8'd5; win_if.win_ready = 1'b1;
        repeat (12) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("async_rst_outs", all_outs(), 0);
        @(negedge clk);
        rst_n = 1'b1; start = 1'b1; cfg_h = 8'd3; cfg_w = 8'd3;
        @(negedge clk);
        start = 1'b0;
        chk("rst_start_accept", {busy, win_if.clear}, 2'b11);
        begin
            int n = 0;
            while (busy && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("rst_pass_end", busy, 0);
        end
        win_if.win_ready = 1'b0;

        for (int i = 0; i < 6; i++)
            run_pass($urandom_range(3, 7), $urandom_range(3, 7), $urandom_range(0, 1));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
